// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds issued ops until both operands
// are available (via issue-time bypass or CDB wakeup), then dispatches one per cycle.
`default_nettype none

module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             issue_valid,
    input  logic [5:0]       issue_inst_name,
    input  logic [31:0]      issue_V1,
    input  logic [31:0]      issue_V2,
    input  logic             issue_Q1_busy,
    input  logic             issue_Q2_busy,
    input  logic [TAG_W-1:0] issue_Q1,
    input  logic [TAG_W-1:0] issue_Q2,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic [TAG_W-1:0] issue_rob_tag,
    output logic             full,
    input  logic             cdb_alu_valid,
    input  logic             cdb_lsb_valid,
    input  logic [TAG_W-1:0] cdb_alu_tag,
    input  logic [TAG_W-1:0] cdb_lsb_tag,
    input  logic [31:0]      cdb_alu_value,
    input  logic [31:0]      cdb_lsb_value,
    output logic [5:0]       alu_inst_name,
    output logic [31:0]      alu_V1,
    output logic [31:0]      alu_V2,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [TAG_W-1:0] alu_rob_tag
);

    localparam logic [5:0] OP_NOP = 6'd0;
    localparam int         IDX_W  = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] valid_q, q1_busy_q, q2_busy_q, ready;
    logic [5:0]         op_q   [RS_SIZE];
    logic [31:0]        v1_q   [RS_SIZE];
    logic [31:0]        v2_q   [RS_SIZE];
    logic [31:0]        imm_q  [RS_SIZE];
    logic [31:0]        pc_q   [RS_SIZE];
    logic [TAG_W-1:0]   q1_q   [RS_SIZE];
    logic [TAG_W-1:0]   q2_q   [RS_SIZE];
    logic [TAG_W-1:0]   tag_q  [RS_SIZE];

    // {busy, value} after snooping both CDBs; the ALU bus wins a tag collision.
    logic [32:0]        wake1 [RS_SIZE];
    logic [32:0]        wake2 [RS_SIZE];
    logic [32:0]        iss1, iss2;
    logic [IDX_W-1:0]   free_idx, disp_idx;
    logic               disp_found, issue_ok;

    function automatic logic [32:0] resolve(input logic busy, input logic [TAG_W-1:0] tag,
                                            input logic [31:0] val);
        if (busy && cdb_alu_valid && cdb_alu_tag == tag) return {1'b0, cdb_alu_value};
        if (busy && cdb_lsb_valid && cdb_lsb_tag == tag) return {1'b0, cdb_lsb_value};
        return {busy, val};
    endfunction

    assign full     = &valid_q;
    assign ready    = valid_q & ~q1_busy_q & ~q2_busy_q;
    assign issue_ok = issue_valid & ~full;

    always_comb begin
        iss1 = resolve(issue_Q1_busy, issue_Q1, issue_V1);
        iss2 = resolve(issue_Q2_busy, issue_Q2, issue_V2);
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1[i] = resolve(q1_busy_q[i], q1_q[i], v1_q[i]);
            wake2[i] = resolve(q2_busy_q[i], q2_q[i], v2_q[i]);
        end
    end

    // Lowest-index free slot and lowest-index ready slot.
    always_comb begin
        free_idx   = '0;
        disp_idx   = '0;
        disp_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
            if (ready[i]) begin
                disp_idx   = IDX_W'(i);
                disp_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q       <= '0;
            q1_busy_q     <= '0;
            q2_busy_q     <= '0;
            alu_inst_name <= OP_NOP;
            alu_V1        <= '0;
            alu_V2        <= '0;
            alu_imm       <= '0;
            alu_pc        <= '0;
            alu_rob_tag   <= '0;
        end else if (flush_in) begin
            valid_q       <= '0;
            alu_inst_name <= OP_NOP;
            alu_V1        <= '0;
            alu_V2        <= '0;
            alu_imm       <= '0;
            alu_pc        <= '0;
            alu_rob_tag   <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid_q[i]) begin
                    q1_busy_q[i] <= wake1[i][32];
                    q2_busy_q[i] <= wake2[i][32];
                end
            end
            if (issue_ok) begin
                valid_q[free_idx]   <= 1'b1;
                q1_busy_q[free_idx] <= iss1[32];
                q2_busy_q[free_idx] <= iss2[32];
            end
            if (disp_found) begin
                valid_q[disp_idx] <= 1'b0;
                alu_inst_name     <= op_q[disp_idx];
                alu_V1            <= v1_q[disp_idx];
                alu_V2            <= v2_q[disp_idx];
                alu_imm           <= imm_q[disp_idx];
                alu_pc            <= pc_q[disp_idx];
                alu_rob_tag       <= tag_q[disp_idx];
            end else begin
                alu_inst_name <= OP_NOP;
                alu_V1        <= '0;
                alu_V2        <= '0;
                alu_imm       <= '0;
                alu_pc        <= '0;
                alu_rob_tag   <= '0;
            end
        end
    end

    // Payload carries no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i]) begin
                v1_q[i] <= wake1[i][31:0];
                v2_q[i] <= wake2[i][31:0];
            end
        end
        if (issue_ok) begin
            op_q[free_idx]  <= issue_inst_name;
            v1_q[free_idx]  <= iss1[31:0];
            v2_q[free_idx]  <= iss2[31:0];
            q1_q[free_idx]  <= issue_Q1;
            q2_q[free_idx]  <= issue_Q2;
            imm_q[free_idx] <= issue_imm;
            pc_q[free_idx]  <= issue_pc;
            tag_q[free_idx] <= issue_rob_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed scenarios followed by random traffic.
`default_nettype none

module tb_alu_rs;
    localparam int RS = 8;
    localparam int TW = 4;
    localparam logic [5:0] NOP  = 6'd0;
    localparam logic [5:0] ADD  = 6'd24;
    localparam logic [5:0] ADDI = 6'd28;
    localparam logic [5:0] ANDI = 6'd37;

    logic clk_in = 1'b0, rst_in = 1'b1, flush_in, issue_valid;
    logic [5:0] issue_inst_name;
    logic [31:0] issue_V1, issue_V2, issue_imm, issue_pc;
    logic issue_Q1_busy, issue_Q2_busy;
    logic [TW-1:0] issue_Q1, issue_Q2, issue_rob_tag;
    logic full;
    logic cdb_alu_valid, cdb_lsb_valid;
    logic [TW-1:0] cdb_alu_tag, cdb_lsb_tag;
    logic [31:0] cdb_alu_value, cdb_lsb_value;
    logic [5:0] alu_inst_name;
    logic [31:0] alu_V1, alu_V2, alu_imm, alu_pc;
    logic [TW-1:0] alu_rob_tag;

    alu_rs #(.RS_SIZE(RS), .TAG_W(TW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .issue_valid(issue_valid), .issue_inst_name(issue_inst_name),
        .issue_V1(issue_V1), .issue_V2(issue_V2),
        .issue_Q1_busy(issue_Q1_busy), .issue_Q2_busy(issue_Q2_busy),
        .issue_Q1(issue_Q1), .issue_Q2(issue_Q2),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_tag(issue_rob_tag),
        .full(full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
        .cdb_alu_tag(cdb_alu_tag), .cdb_lsb_tag(cdb_lsb_tag),
        .cdb_alu_value(cdb_alu_value), .cdb_lsb_value(cdb_lsb_value),
        .alu_inst_name(alu_inst_name), .alu_V1(alu_V1), .alu_V2(alu_V2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_tag(alu_rob_tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [5:0] op; logic [31:0] v1, v2, imm, pc; logic [TW-1:0] tag; int cyc;
    } disp_t;
    typedef struct {
        bit valid; logic [5:0] op; logic [31:0] v1, v2, imm, pc;
        bit b1, b2; logic [TW-1:0] q1, q2, tag;
    } ent_t;

    disp_t exp_q[$];
    ent_t  m[RS];
    int    edge_cnt = 0;
    int    total = 0;
    int    bad = 0;

    always @(posedge clk_in) edge_cnt++;

    task automatic chk(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A pending operand picks up whatever the buses broadcast for its tag, ALU bus first.
    task automatic snoop(input bit b, input logic [TW-1:0] q, input logic [31:0] v,
                         output bit bo, output logic [31:0] vo);
        bo = b; vo = v;
        if (b && cdb_alu_valid && cdb_alu_tag == q) begin bo = 0; vo = cdb_alu_value; end
        else if (b && cdb_lsb_valid && cdb_lsb_tag == q) begin bo = 0; vo = cdb_lsb_value; end
    endtask

    function automatic bit model_full();
        for (int i = 0; i < RS; i++) if (!m[i].valid) return 1'b0;
        return 1'b1;
    endfunction

    // Applies the current inputs to the model for the upcoming clock edge.
    task automatic model_edge();
        int d = -1, f = -1;
        bit was_full;
        disp_t e;
        if (!rst_in || flush_in) begin
            for (int i = 0; i < RS; i++) m[i].valid = 0;
            return;
        end
        was_full = model_full();
        for (int i = 0; i < RS; i++) begin
            if (d < 0 && m[i].valid && !m[i].b1 && !m[i].b2) d = i;
            if (f < 0 && !m[i].valid) f = i;
        end
        if (d >= 0) begin
            e.op = m[d].op; e.v1 = m[d].v1; e.v2 = m[d].v2; e.imm = m[d].imm;
            e.pc = m[d].pc; e.tag = m[d].tag; e.cyc = edge_cnt + 1;
            exp_q.push_back(e);
        end
        for (int i = 0; i < RS; i++) if (m[i].valid) begin
            snoop(m[i].b1, m[i].q1, m[i].v1, m[i].b1, m[i].v1);
            snoop(m[i].b2, m[i].q2, m[i].v2, m[i].b2, m[i].v2);
        end
        if (d >= 0) m[d].valid = 0;
        if (issue_valid && !was_full) begin
            m[f].valid = 1; m[f].op = issue_inst_name; m[f].imm = issue_imm;
            m[f].pc = issue_pc; m[f].tag = issue_rob_tag;
            m[f].q1 = issue_Q1; m[f].q2 = issue_Q2;
            snoop(issue_Q1_busy, issue_Q1, issue_V1, m[f].b1, m[f].v1);
            snoop(issue_Q2_busy, issue_Q2, issue_V2, m[f].b2, m[f].v2);
        end
    endtask

    // Monitor: reacts only to what the DUT presents after each edge.
    always @(posedge clk_in) begin
        #2;
        begin : mon
            disp_t e;
            bit ok;
            chk("full", full === model_full(), 64'(full), 64'(model_full()));
            if (alu_inst_name !== NOP) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dispatch", 1'b0, {alu_inst_name, alu_rob_tag, alu_V1}, 0);
                end else begin
                    e = exp_q.pop_front();
                    ok = alu_inst_name === e.op && alu_V1 === e.v1 && alu_V2 === e.v2 &&
                         alu_imm === e.imm && alu_pc === e.pc && alu_rob_tag === e.tag &&
                         e.cyc == edge_cnt;
                    chk("dispatch", ok, {alu_inst_name, alu_rob_tag, alu_V1, alu_V2[15:0]},
                        {e.op, e.tag, e.v1, e.v2[15:0]});
                end
            end else begin
                chk("idle_zero", {alu_V1, alu_V2, alu_imm, alu_pc, alu_rob_tag} === '0,
                    {alu_V1, alu_V2}, 0);
                if (exp_q.size() != 0 && exp_q[0].cyc <= edge_cnt) begin
                    e = exp_q.pop_front();
                    chk("missing_dispatch", 1'b0, 64'(alu_inst_name), {e.op, e.tag, e.v1});
                end
            end
        end
    end

    task automatic idle();
        issue_valid = 0; issue_inst_name = NOP; issue_V1 = 0; issue_V2 = 0;
        issue_Q1_busy = 0; issue_Q2_busy = 0; issue_Q1 = 0; issue_Q2 = 0;
        issue_imm = 0; issue_pc = 0; issue_rob_tag = 0; flush_in = 0;
        cdb_alu_valid = 0; cdb_lsb_valid = 0; cdb_alu_tag = 0; cdb_lsb_tag = 0;
        cdb_alu_value = 0; cdb_lsb_value = 0;
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk_in);
        idle();
    endtask

    task automatic iss(input logic [5:0] op, input logic [31:0] v1, input bit b1,
                       input logic [TW-1:0] q1, input logic [31:0] v2, input bit b2,
                       input logic [TW-1:0] q2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [TW-1:0] tag);
        issue_valid = 1; issue_inst_name = op; issue_V1 = v1; issue_Q1_busy = b1;
        issue_Q1 = q1; issue_V2 = v2; issue_Q2_busy = b2; issue_Q2 = q2;
        issue_imm = imm; issue_pc = pc; issue_rob_tag = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        #2 rst_in = 0;
        repeat (2) @(negedge clk_in);
        chk("reset_op", alu_inst_name === NOP, 64'(alu_inst_name), 64'(NOP));
        chk("reset_full", full === 1'b0, 64'(full), 0);
        rst_in = 1;

        // Ready ADDI dispatches one edge after issue, then NOP.
        iss(ADDI, 5, 0, 0, 0, 0, 0, 3, 32'h100, 2); tick();
        chk("addi_early", alu_inst_name === NOP, 64'(alu_inst_name), 64'(NOP));
        tick();
        chk("addi_op", alu_inst_name === ADDI, 64'(alu_inst_name), 64'(ADDI));
        chk("addi_ops", {alu_V1, alu_imm, alu_rob_tag} === {32'd5, 32'd3, 4'd2},
            {alu_V1, alu_imm}, {32'd5, 32'd3});
        tick();
        chk("addi_once", alu_inst_name === NOP, 64'(alu_inst_name), 64'(NOP));

        // Wakeup from the load-store bus.
        iss(ADD, 0, 1, 7, 1, 0, 0, 0, 32'h104, 1); tick(); tick();
        cdb_lsb_valid = 1; cdb_lsb_tag = 7; cdb_lsb_value = 32'h10; tick();
        chk("wake_wait", alu_inst_name === NOP, 64'(alu_inst_name), 64'(NOP));
        tick();
        chk("wake_disp", {alu_inst_name, alu_V1, alu_V2} === {ADD, 32'h10, 32'd1},
            {alu_V1, alu_V2}, {32'h10, 32'd1});

        // Issue-time bypass from the ALU bus.
        iss(ADD, 4, 0, 0, 0, 1, 3, 0, 32'h108, 5);
        cdb_alu_valid = 1; cdb_alu_tag = 3; cdb_alu_value = 9; tick(); tick();
        chk("bypass", {alu_inst_name, alu_V1, alu_V2} === {ADD, 32'd4, 32'd9},
            {alu_V1, alu_V2}, {32'd4, 32'd9});

        // Fill, ignore extra issue, wake slot 5, reuse it.
        for (int i = 0; i < RS; i++) begin
            iss(ADD, i, 1, TW'(8 + i), 1, 0, 0, 0, 32'h200 + i, TW'(i)); tick();
        end
        chk("full_set", full === 1'b1, 64'(full), 1);
        iss(ADDI, 1, 0, 0, 2, 0, 0, 0, 32'h300, 15); tick();
        chk("full_ignored", full === 1'b1 && alu_inst_name === NOP, 64'(alu_inst_name), 0);
        cdb_alu_valid = 1; cdb_alu_tag = 13; cdb_alu_value = 32'hAB; tick(); tick();
        chk("slot5_disp", {alu_rob_tag, alu_V1} === {4'd5, 32'hAB}, {alu_rob_tag, alu_V1},
            {4'd5, 32'hAB});
        chk("slot5_free", full === 1'b0, 64'(full), 0);
        iss(ANDI, 7, 0, 0, 8, 0, 0, 1, 32'h400, 9); tick();
        chk("slot5_reuse", full === 1'b1, 64'(full), 1);
        tick();
        chk("reuse_disp", {alu_inst_name, alu_rob_tag} === {ANDI, 4'd9},
            {alu_inst_name, alu_rob_tag}, {ANDI, 4'd9});
        flush_in = 1; tick();
        chk("flush_clear", full === 1'b0, 64'(full), 0);

        // Three woken entries killed by flush.
        for (int i = 0; i < 3; i++) begin
            iss(ADD, i, 1, 6, 0, 0, 0, 0, 32'h500 + i, TW'(i)); tick();
        end
        cdb_alu_valid = 1; cdb_alu_tag = 6; cdb_alu_value = 1; tick();
        flush_in = 1; tick();
        chk("flush_nop", alu_inst_name === NOP && full === 1'b0, 64'(alu_inst_name), 0);
        repeat (4) tick();

        // Asynchronous reset between edges with a ready entry pending.
        iss(ADD, 1, 0, 0, 1, 0, 0, 0, 32'h600, 1); tick();
        iss(ADD, 2, 0, 0, 2, 0, 0, 0, 32'h604, 2); tick();
        iss(ADD, 3, 0, 0, 3, 0, 0, 0, 32'h608, 3); tick();
        chk("pre_reset", {alu_inst_name, alu_rob_tag} === {ADD, 4'd2},
            {alu_inst_name, alu_rob_tag}, {ADD, 4'd2});
        #1 rst_in = 0;
        #1 chk("async_reset", {alu_inst_name, alu_V1, alu_rob_tag, full} === '0,
               {alu_inst_name, alu_V1}, 0);
        tick(); tick();
        rst_in = 1;
        repeat (3) tick();
        chk("post_reset_nop", alu_inst_name === NOP, 64'(alu_inst_name), 64'(NOP));

        // Random traffic against the model.
        repeat (1500) begin
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_inst_name = 6'($urandom_range(1, 37));
            issue_V1 = $urandom; issue_V2 = $urandom;
            issue_Q1_busy = 1'($urandom_range(0, 1)); issue_Q2_busy = 1'($urandom_range(0, 1));
            issue_Q1 = TW'($urandom_range(0, 15)); issue_Q2 = TW'($urandom_range(0, 15));
            issue_imm = $urandom; issue_pc = $urandom; issue_rob_tag = TW'($urandom);
            cdb_alu_valid = 1'($urandom_range(0, 1)); cdb_lsb_valid = 1'($urandom_range(0, 1));
            cdb_alu_tag = TW'($urandom_range(0, 15)); cdb_lsb_tag = TW'($urandom_range(0, 15));
            cdb_alu_value = $urandom; cdb_lsb_value = $urandom;
            flush_in = ($urandom_range(0, 49) == 0);
            tick();
        end
        repeat (12) tick();
        chk("queue_drained", exp_q.size() == 0, 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, meaning number of reservation entries (power of two).
REQ-002 SHALL have parameter TAG_W, default 4, meaning ROB tag width.
REQ-003 SHALL have clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have flush_in  input  1  mispredict rollback; synchronous clear of all entries.
REQ-006 SHALL have issue_valid  input  1  decoder presents a new instruction this cycle.
REQ-007 SHALL have issue_inst_name  input  6  operation code from the shared defines (`NOP .. `ANDI).
REQ-008 SHALL have issue_V1, issue_V2  input  32 each  operand values, meaningful only when not busy.
REQ-009 SHALL have issue_Q1_busy, issue_Q2_busy  input  1 each  operand still pending.
REQ-010 SHALL have issue_Q1, issue_Q2  input  TAG_W each  producer ROB tag of pending operand.
REQ-011 SHALL have issue_imm, issue_pc  input  32 each  immediate and instruction pc.
REQ-012 SHALL have issue_rob_tag  input  TAG_W  destination ROB tag.
REQ-013 SHALL have full  output  1  all RS_SIZE entries occupied (combinational from entry valid bits).
REQ-014 SHALL have cdb_alu_valid, cdb_lsb_valid  input  1 each  result broadcast on ALU / load-store CDB.
REQ-015 SHALL have cdb_alu_tag, cdb_lsb_tag  input  TAG_W each  broadcast ROB tag.
REQ-016 SHALL have cdb_alu_value, cdb_lsb_value  input  32 each  broadcast value.
REQ-017 SHALL have alu_inst_name  output  6  registered op to ALU; `NOP when idle.
REQ-018 SHALL have alu_V1, alu_V2, alu_imm, alu_pc  output  32 each  registered operands to ALU.
REQ-019 SHALL have alu_rob_tag  output  TAG_W  registered tag accompanying the dispatched op.

Function
REQ-020 Entry state: valid, inst_name, V1, Q1, Q1_busy, V2, Q2, Q2_busy, imm, pc, rob_tag.
REQ-021 Issue: when issue_valid and not full, SHALL write the lowest-index free entry at the edge; issue_valid while full SHALL be ignored (no entry written, no state change).
REQ-022 Issue-time bypass: if an issuing operand is busy and its tag equals a valid CDB tag in the same cycle, entry SHALL store the CDB value with busy cleared.
REQ-023 Wakeup: each valid entry with Qx_busy and Qx equal to a valid CDB tag SHALL load Vx from that CDB and clear Qx_busy at the edge; both CDBs and both operands update independently in one cycle.
REQ-024 If both CDBs carry the same tag in one cycle, cdb_alu value SHALL win.
REQ-025 Ready: entry valid with Q1_busy=0 and Q2_busy=0, evaluated on registered state only.
REQ-026 Dispatch: each edge, the lowest-index ready entry SHALL be copied to the alu_* output registers and its valid cleared at that same edge.
REQ-027 No ready entry: alu_inst_name SHALL be `NOP, other alu_* outputs SHALL be 0.
REQ-028 Output registers hold for exactly one cycle; a dispatched op SHALL never appear twice.
REQ-029 Latency: issue at edge k with ready operands -> alu_* valid after edge k+1; entry woken at edge k -> dispatch at edge k+1.
REQ-030 Issue and dispatch in the same edge SHALL both take effect; a slot freed at edge k is reusable from edge k+1.
REQ-031 At most one issue and one dispatch per cycle.
REQ-032 flush_in SHALL, at the edge, clear all entry valid bits and force alu_inst_name=`NOP, overriding issue, wakeup and dispatch that cycle.

Reset
REQ-033 rst_in low SHALL immediately clear all entry valid bits, busy bits, and alu_* outputs (alu_inst_name=`NOP, others 0), independent of clk_in.
REQ-034 After reset full=0; first issue permitted at the first edge after rst_in rises.
REQ-035 Reset asserted mid-operation SHALL discard all pending entries with no dispatch emitted.

Verification
REQ-036 Issue ADDI V1=5 imm=3 tag=2 ready -> one cycle later alu_inst_name=ADDI, alu_V1=5, alu_imm=3, alu_rob_tag=2; next cycle `NOP.
REQ-037 Issue ADD Q1=7 busy, V2=1; cdb_lsb tag=7 value=0x10 two cycles later -> dispatch on following edge with alu_V1=0x10, alu_V2=1.
REQ-038 Issue with Q2=3 busy while cdb_alu tag=3 value=9 same cycle -> entry stored ready, dispatch next edge with alu_V2=9.
REQ-039 Fill 8 dependent entries -> full=1; extra issue_valid ignored; wake entry 5 -> it dispatches, full=0 next cycle, new issue lands in slot 5.
REQ-040 Three ready entries then flush_in -> alu_inst_name=`NOP next cycle, full=0, no stored op ever dispatched.
REQ-041 Assert rst_in low between edges with ready entries -> outputs `NOP/0 immediately, nothing dispatched after release.
